seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive-side counterpart of the hex-to-7-segment driver. It monitors a multiplexed
//  4-digit active-low display bus (anodes + segments) and recovers the displayed hex nibbles.
//  Each digit pattern is filtered for stability and then decoded back to 4 bits.
//  Used in self-check and loopback of the display path, and to read values off a board harness.
// PARAMETERS
//  STABLE_CYCLES  4   consecutive identical samples of {an_n,seg_n,dp_n} required before capture (>=2)
//  CNT_W          8   width of stability counter; 2**CNT_W must be > STABLE_CYCLES
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-high reset
//  an_n       in   4   digit selects, active low; bit i = digit i (digit 0 = hex[3:0])
//  seg_n      in   7   segments, active low, {a,b,c,d,e,f,g} = seg_n[6:0]
//  dp_n       in   1   decimal point, active low
//  hex        out  16  recovered nibbles, digit i at hex[4i+3:4i]
//  dig_valid  out  4   digit i holds a successfully decoded value
//  dig_err    out  4   last capture of digit i was an unknown pattern
//  dp_seen    out  4   dp state (1 = lit) at the last capture of digit i
//  upd        out  1   one-cycle pulse: a capture occurred
//  upd_idx    out  2   digit index of that capture (held until the next capture)
//  frame      out  1   one-cycle pulse: all 4 digits captured since the last frame pulse
// BEHAVIOUR
//  Clock and reset:
//  - One clock (clk). Reset is synchronous and active-high (rst).
//  - Reset values: hex=0, dig_valid=0, dig_err=0, dp_seen=0, upd=0, upd_idx=0, frame=0.
//  - Reset also clears the input register, the stability counter and the frame-seen mask.
//  - Reset mid-stability count aborts it; there is no capture in the reset cycle.
//  Sampling and stability filter:
//  - Inputs are registered once into sample S. Counter C tracks how long S has been unchanged.
//  - If the new input equals S, C increments and saturates at STABLE_CYCLES.
//  - If the new input differs from S, C = 0.
//  - Capture fires exactly once per stable period: on the cycle C reaches STABLE_CYCLES-1 (not while held).
//  - Latency: inputs held constant from clock edge k -> upd is high in the cycle after edge k+STABLE_CYCLES.
//  - Capture only if an_n has exactly one zero. Patterns 4'b1111 and multi-low (ghosting) are ignored: no upd.
//  Decode at capture, seg_n -> nibble (abcdefg):
//   0000001=0  1001111=1  0010010=2  0000110=3  1001100=4  0100100=5  0100000=6  0001101=7
//   0000000=8  0000100=9  0000010=A  1100000=b  0110001=C  1000010=d  0110000=E  0111000=F
//  - Known pattern: write hex nibble i; dig_valid[i]=1; dig_err[i]=0.
//  - seg_n=1111111 (blank): hex nibble i unchanged; dig_valid[i]=0; dig_err[i]=0.
//  - Any other pattern: hex nibble i unchanged; dig_valid[i]=0; dig_err[i]=1.
//  - On every capture: dp_seen[i]=~dp_n; upd=1; upd_idx=i.
//  Frame:
//  - A 4-bit seen mask ORs in bit i on each capture, including blank and error captures.
//  - When the mask becomes 1111, frame pulses in the same cycle as that upd, and the mask clears.
//  - Recapture of an already-seen digit does not advance the frame.
//  - All outputs are registered; upd and frame are never high for two consecutive cycles.
//  - The decode table is exhaustive as listed; no X propagates from unknown input codes.
// TESTING
//  1 Reset: rst=1 for 2 cycles with arbitrary inputs -> every output 0 the cycle after;
//    no upd while rst is high.
//  2 an_n=1110, seg_n=0010010, dp_n=1 held 4 clk (STABLE_CYCLES=4) -> single upd, upd_idx=0,
//    hex[3:0]=2, dig_valid=0001, dp_seen[0]=0; hold 20 more clk -> no further upd.
//  3 Glitch: same as 2 but seg_n toggles to 0000000 for 1 clk at cycle 2 -> counter restarts;
//    upd only after 4 more stable clk, hex[3:0]=2.
//  4 Full scan: digits 3..0 show F,d,1,8 (0111000,1000010,1001111,0000000), 8 clk each ->
//    hex=16'hFD18, dig_valid=1111, frame pulses with the 4th upd only.
//  5 Errors/blank: an_n=1011, seg_n=1010101 -> dig_err[2]=1, dig_valid[2]=0, hex[11:8] kept;
//    then seg_n=1111111 -> dig_err[2]=0, dig_valid[2]=0.
//  6 Ghost/reset: an_n=1100 held 10 clk -> no upd; valid select held 3 clk, rst at 3rd -> no upd,
//    and the count restarts from 0 after rst falls.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Watches a multiplexed 4-digit active-low 7-segment bus and recovers the
//   hex nibble shown on each digit. Every {an_n,seg_n,dp_n} pattern must be
//   seen unchanged for STABLE_CYCLES samples before it is captured. On capture,
//   the segment pattern is decoded back to a nibble, or flagged as blank or unknown.
//
// Ports
//   clk, rst     clock, synchronous active-high reset
//   an_n[3:0]    digit selects, active low (bit i = digit i)
//   seg_n[6:0]   segments {a,b,c,d,e,f,g}, active low
//   dp_n         decimal point, active low
//   hex[15:0]    recovered nibbles, digit i at hex[4i+3:4i]
//   dig_valid    digit i holds a decoded value
//   dig_err      last capture of digit i was an unknown pattern
//   dp_seen      decimal point lit at the last capture of digit i
//   upd          one-cycle capture pulse
//   upd_idx      digit index of the last capture
//   frame        one-cycle pulse once all 4 digits have been captured
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an_n,
  input  logic [6:0]  seg_n,
  input  logic        dp_n,
  output logic [15:0] hex,
  output logic [3:0]  dig_valid,
  output logic [3:0]  dig_err,
  output logic [3:0]  dp_seen,
  output logic        upd,
  output logic [1:0]  upd_idx,
  output logic        frame
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

  // Returns {known, nibble}; anything outside the table decodes as unknown.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      7'b0000001: r = {1'b1, 4'h0};
      7'b1001111: r = {1'b1, 4'h1};
      7'b0010010: r = {1'b1, 4'h2};
      7'b0000110: r = {1'b1, 4'h3};
      7'b1001100: r = {1'b1, 4'h4};
      7'b0100100: r = {1'b1, 4'h5};
      7'b0100000: r = {1'b1, 4'h6};
      7'b0001101: r = {1'b1, 4'h7};
      7'b0000000: r = {1'b1, 4'h8};
      7'b0000100: r = {1'b1, 4'h9};
      7'b0000010: r = {1'b1, 4'hA};
      7'b1100000: r = {1'b1, 4'hB};
      7'b0110001: r = {1'b1, 4'hC};
      7'b1000010: r = {1'b1, 4'hD};
      7'b0110000: r = {1'b1, 4'hE};
      7'b0111000: r = {1'b1, 4'hF};
      default:    r = 5'h00;
    endcase
    return r;
  endfunction

  function automatic logic one_low(input logic [3:0] a);
    return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] a);
    logic [1:0] r;
    r = 2'd0;
    case (a)
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [11:0]      in_w;
  logic [11:0]      smp_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             cap_p0;
  logic [1:0]       idx_p0;
  logic [4:0]       dec_p0;
  logic [3:0]       mask_q;
  logic [3:0]       mask_nxt;

  assign in_w = {an_n, seg_n, dp_n};

  // Stage p0: input sample and stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_p0 <= '0;
      cnt_p0 <= '0;
    end else begin
      smp_p0 <= in_w;
      if (in_w != smp_p0)
        cnt_p0 <= '0;
      else if (cnt_p0 != CNT_SAT)
        cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  // Capture decision: the counter passes STABLE_CYCLES-1 only once per
  // stable period (it then saturates or restarts), giving a single capture.
  always_comb begin
    cap_p0   = (cnt_p0 == CNT_CAP) && one_low(smp_p0[11:8]);
    idx_p0   = low_idx(smp_p0[11:8]);
    dec_p0   = seg_decode(smp_p0[7:1]);
    mask_nxt = mask_q | (4'b0001 << idx_p0);
  end

  // Stage p1: registered outputs and frame tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      hex       <= '0;
      dig_valid <= '0;
      dig_err   <= '0;
      dp_seen   <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      frame     <= 1'b0;
      mask_q    <= '0;
    end else begin
      upd   <= cap_p0;
      frame <= cap_p0 && (mask_nxt == 4'hF);
      if (cap_p0) begin
        upd_idx         <= idx_p0;
        dp_seen[idx_p0] <= ~smp_p0[0];
        if (dec_p0[4]) begin
          hex[{idx_p0, 2'b00} +: 4] <= dec_p0[3:0];
          dig_valid[idx_p0]         <= 1'b1;
          dig_err[idx_p0]           <= 1'b0;
        end else begin
          // Blank digit clears both flags; any other unknown pattern is an error.
          dig_valid[idx_p0] <= 1'b0;
          dig_err[idx_p0]   <= (smp_p0[7:1] != 7'h7F);
        end
        mask_q <= (mask_nxt == 4'hF) ? 4'h0 : mask_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder
//   Self-checking bench for seg_scan_decoder: expected captures are queued
//   when stimulus is driven and compared when upd pulses.
module tb_seg_scan_decoder;

  localparam int STABLE = 4;

  localparam logic [6:0] TBL [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001101,
    7'b0000000, 7'b0000100, 7'b0000010, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  typedef struct {
    logic [1:0]  idx;
    logic [15:0] hex;
    logic [3:0]  vld;
    logic [3:0]  err;
    logic [3:0]  dp;
    logic        frame;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [15:0] hex;
  logic [3:0]  dig_valid;
  logic [3:0]  dig_err;
  logic [3:0]  dp_seen;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        frame;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];
  logic mon_en = 1'b0;

  logic [15:0] m_hex;
  logic [3:0]  m_vld, m_err, m_dp, m_mask;

  always #5 clk = ~clk;

  seg_scan_decoder #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n),
    .hex(hex), .dig_valid(dig_valid), .dig_err(dig_err), .dp_seen(dp_seen),
    .upd(upd), .upd_idx(upd_idx), .frame(frame)
  );

  task automatic model_reset();
    m_hex  = '0;
    m_vld  = '0;
    m_err  = '0;
    m_dp   = '0;
    m_mask = '0;
    q.delete();
  endtask

  task automatic expect_cap(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    logic [1:0] i;
    int         k;
    exp_t       e;
    i = (an == 4'b1110) ? 2'd0 : (an == 4'b1101) ? 2'd1 : (an == 4'b1011) ? 2'd2 : 2'd3;
    k = -1;
    for (int j = 0; j < 16; j++) if (TBL[j] == seg) k = j;
    if (k >= 0) begin
      m_hex[{i, 2'b00} +: 4] = 4'(k);
      m_vld[i] = 1'b1;
      m_err[i] = 1'b0;
    end else begin
      m_vld[i] = 1'b0;
      m_err[i] = (seg != 7'h7F);
    end
    m_dp[i]   = ~dp;
    m_mask[i] = 1'b1;
    e.frame   = (m_mask == 4'hF);
    if (e.frame) m_mask = 4'h0;
    e.idx = i;
    e.hex = m_hex;
    e.vld = m_vld;
    e.err = m_err;
    e.dp  = m_dp;
    q.push_back(e);
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input logic dp);
    an_n  = an;
    seg_n = seg;
    dp_n  = dp;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      if (upd === 1'b1) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_upd: got upd with idx=%0d, required no capture", upd_idx);
        end else begin
          e = q.pop_front();
          total++; if (upd_idx !== e.idx) begin bad++; $display("FAIL upd_idx: got %0d required %0d", upd_idx, e.idx); end
          total++; if (hex !== e.hex) begin bad++; $display("FAIL hex: got %h required %h", hex, e.hex); end
          total++; if (dig_valid !== e.vld) begin bad++; $display("FAIL dig_valid: got %b required %b", dig_valid, e.vld); end
          total++; if (dig_err !== e.err) begin bad++; $display("FAIL dig_err: got %b required %b", dig_err, e.err); end
          total++; if (dp_seen !== e.dp) begin bad++; $display("FAIL dp_seen: got %b required %b", dp_seen, e.dp); end
          total++; if (frame !== e.frame) begin bad++; $display("FAIL frame: got %b required %b", frame, e.frame); end
        end
      end else begin
        total++;
        if (upd !== 1'b0 || frame !== 1'b0) begin
          bad++;
          $display("FAIL idle_pulse: got upd=%b frame=%b required 0 0", upd, frame);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    drive(4'($urandom), 7'($urandom), 1'($urandom));
    @(negedge clk);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_upd1: got %b required 0", upd); end
    @(negedge clk);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL reset_upd2: got %b required 0", upd); end
    rst = 1'b0;
    drive(4'hF, 7'h7F, 1'b1);
    model_reset();
    total++;
    if (hex !== 16'h0 || dig_valid !== 4'h0 || dig_err !== 4'h0 || dp_seen !== 4'h0 ||
        upd_idx !== 2'd0 || frame !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got hex=%h vld=%b err=%b dp=%b idx=%0d frame=%b required all 0",
               hex, dig_valid, dig_err, dp_seen, upd_idx, frame);
    end
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int n;
    expect_cap(4'b1110, 7'b0010010, 1'b1);
    drive(4'b1110, 7'b0010010, 1'b1);
    repeat (STABLE) @(negedge clk);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL single_early: got upd=%b required 0", upd); end
    @(negedge clk);
    total++; if (upd !== 1'b1) begin bad++; $display("FAIL single_latency: got upd=%b required 1", upd); end
    total++; if (hex[3:0] !== 4'h2) begin bad++; $display("FAIL single_hex: got %h required 2", hex[3:0]); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (upd === 1'b1) n++;
    end
    total++; if (n != 0) begin bad++; $display("FAIL single_hold: got %0d extra upd required 0", n); end
  endtask

  task automatic test_glitch();
    int n;
    drive(4'hF, 7'h7F, 1'b1);
    repeat (2) @(negedge clk);
    expect_cap(4'b1110, 7'b0010010, 1'b1);
    drive(4'b1110, 7'b0010010, 1'b1);
    repeat (2) @(negedge clk);
    drive(4'b1110, 7'b0000000, 1'b1);
    @(negedge clk);
    drive(4'b1110, 7'b0010010, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (upd !== 1'b1 && n < 20);
    total++; if (n != STABLE + 1) begin bad++; $display("FAIL glitch_latency: got %0d cycles required %0d", n, STABLE + 1); end
    total++; if (hex[3:0] !== 4'h2) begin bad++; $display("FAIL glitch_hex: got %h required 2", hex[3:0]); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_full_scan();
    logic [3:0] ans  [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    logic [6:0] segs [4] = '{7'b0111000, 7'b1000010, 7'b1001111, 7'b0000000};
    int nu, nf, fpos;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    nu = 0; nf = 0; fpos = 0;
    for (int d = 0; d < 4; d++) begin
      expect_cap(ans[d], segs[d], 1'b1);
      drive(ans[d], segs[d], 1'b1);
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (upd === 1'b1) nu++;
        if (frame === 1'b1) begin nf++; fpos = nu; end
      end
    end
    total++; if (hex !== 16'hFD18) begin bad++; $display("FAIL scan_hex: got %h required FD18", hex); end
    total++; if (dig_valid !== 4'hF) begin bad++; $display("FAIL scan_valid: got %b required 1111", dig_valid); end
    total++; if (nu != 4) begin bad++; $display("FAIL scan_upd_count: got %0d required 4", nu); end
    total++; if (nf != 1 || fpos != 4) begin bad++; $display("FAIL scan_frame: got %0d frames at upd %0d required 1 at upd 4", nf, fpos); end
  endtask

  task automatic test_err_blank();
    expect_cap(4'b1011, 7'b1010101, 1'b0);
    drive(4'b1011, 7'b1010101, 1'b0);
    repeat (7) @(negedge clk);
    total++; if (dig_err[2] !== 1'b1 || dig_valid[2] !== 1'b0) begin bad++; $display("FAIL err_flags: got err=%b vld=%b required 1 0", dig_err[2], dig_valid[2]); end
    total++; if (hex[11:8] !== 4'hD) begin bad++; $display("FAIL err_hex_kept: got %h required D", hex[11:8]); end
    total++; if (dp_seen[2] !== 1'b1) begin bad++; $display("FAIL err_dp: got %b required 1", dp_seen[2]); end
    expect_cap(4'b1011, 7'h7F, 1'b1);
    drive(4'b1011, 7'h7F, 1'b1);
    repeat (7) @(negedge clk);
    total++; if (dig_err[2] !== 1'b0 || dig_valid[2] !== 1'b0) begin bad++; $display("FAIL blank_flags: got err=%b vld=%b required 0 0", dig_err[2], dig_valid[2]); end
    total++; if (hex[11:8] !== 4'hD) begin bad++; $display("FAIL blank_hex_kept: got %h required D", hex[11:8]); end
  endtask

  task automatic test_ghost_reset();
    int n;
    drive(4'b1100, 7'b0000001, 1'b1);
    repeat (10) @(negedge clk);
    drive(4'b1111, 7'b0000001, 1'b1);
    repeat (10) @(negedge clk);
    total++; if (q.size() != 0) begin bad++; $display("FAIL ghost_pending: got %0d queued required 0", q.size()); end
    drive(4'b1110, 7'b1001100, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++; if (upd !== 1'b0) begin bad++; $display("FAIL rst_mid_upd: got %b required 0", upd); end
    rst = 1'b0;
    model_reset();
    expect_cap(4'b1110, 7'b1001100, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (upd !== 1'b1 && n < 20);
    total++; if (n != STABLE + 1) begin bad++; $display("FAIL rst_restart_latency: got %0d cycles required %0d", n, STABLE + 1); end
    total++; if (hex !== 16'h0004) begin bad++; $display("FAIL rst_restart_hex: got %h required 0004", hex); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_full_scan();
    test_err_blank();
    test_ghost_reset();
    repeat (3) @(negedge clk);
    total++; if (q.size() != 0) begin bad++; $display("FAIL drain: got %0d captures missing required 0", q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
